// File: rtl/quad_gen.sv
// -----------------------------------------------------------------------------
// quad_gen -- quadrature encoder generator
//
// Drives a quadA/quadB pair so that the reported position walks, one
// quadrature edge per prescaler tick, towards a commanded target. The walk
// always takes the shorter way round the modulo-2^W circle. An exact
// half-circle distance is taken upwards.
//
// The phase convention matches the on-board quadrature decoder:
//   up   : 00 -> 10 -> 11 -> 01 -> 00   ({quadA, quadB})
//   down : 00 -> 01 -> 11 -> 10 -> 00
// A decoder looped back from quadA/quadB therefore counts in step with
// `position`.
//
// Parameters
//   W    position / target width in bits
//   DIV  clocks per quadrature edge (legal 4..65535). The decoder's 3-stage
//        synchroniser needs at least 4 clocks between edges.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset (priority over everything)
//   target    commanded position, sampled only when load=1
//   load      one-clock strobe latching target into the target register
//   quadA     quadrature channel A (registered)
//   quadB     quadrature channel B (registered)
//   position  current generated position (registered)
//   busy      high while position != latched target (combinational from flops)
//   index     only with QUAD_GEN_INDEX_EN: registered Z-channel emulation,
//             high exactly while position = 0 and {quadA, quadB} = 00,
//             reset value 1
//
// Optional feature macro: QUAD_GEN_INDEX_EN
// -----------------------------------------------------------------------------
module quad_gen #(
  parameter int unsigned W   = 8,
  parameter int unsigned DIV = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] target,
  input  logic         load,
  output logic         quadA,
  output logic         quadB,
  output logic [W-1:0] position,
  output logic         busy
`ifdef QUAD_GEN_INDEX_EN
  ,
  output logic         index
`endif
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // Phase states, encoded directly as {quadA, quadB} so the outputs are the
  // state flops themselves and no decode glitch can reach the pins.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // The prescaler is sized for the largest legal DIV.
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [W-1:0] POS_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] POS_ZERO = {W{1'b0}};
  // Half-circle distance: the tie that resolves upwards.
  localparam logic [W-1:0] POS_HALF = {1'b1, {(W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Phase successor: one Gray step up or down. Exactly one channel toggles.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic up);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = up ? PH_10 : PH_01;
      PH_10:   nxt = up ? PH_11 : PH_00;
      PH_11:   nxt = up ? PH_01 : PH_10;
      PH_01:   nxt = up ? PH_00 : PH_11;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    phase_q,    phase_d;
  logic [W-1:0]  position_q, position_d;
  logic [W-1:0]  target_q,   target_d;
  logic [CW-1:0] cnt_q,      cnt_d;
`ifdef QUAD_GEN_INDEX_EN
  logic          index_q,    index_d;
`endif

  logic          busy_s;
  logic          tick_s;
  logic          step_up_s;
  logic [W-1:0]  diff_s;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Direction and busy are derived from the registered target, so a load
    // landing on the same edge as a tick cannot influence that tick's step.
    busy_s    = (position_q != target_q);
    diff_s    = target_q - position_q;
    // Distances 1 .. 2^(W-1) go up; the MSB-set range above the tie goes down.
    step_up_s = (diff_s[W-1] == 1'b0) || (diff_s == POS_HALF);
    tick_s    = busy_s && (cnt_q == CNT_LAST);

    // Retargeting does not touch the prescaler; only busy gates it.
    if (load) begin
      target_d = target;
    end else begin
      target_d = target_q;
    end

    if (!busy_s) begin
      cnt_d = CNT_ZERO;
    end else if (tick_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Position and phase move together on the same edge.
    if (tick_s) begin
      phase_d = next_phase(phase_q, step_up_s);
      if (step_up_s) begin
        position_d = position_q + POS_ONE;
      end else begin
        position_d = position_q - POS_ONE;
      end
    end else begin
      phase_d    = phase_q;
      position_d = position_q;
    end

`ifdef QUAD_GEN_INDEX_EN
    // Computed from the next state so index lines up with the registered
    // position/phase it describes.
    index_d = (position_d == POS_ZERO) && (phase_d == PH_00);
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers with synchronous reset; reset wins over load and pending steps
  // and drops the outputs straight to 00.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= PH_00;
      position_q <= POS_ZERO;
      target_q   <= POS_ZERO;
      cnt_q      <= CNT_ZERO;
`ifdef QUAD_GEN_INDEX_EN
      index_q    <= 1'b1;
`endif
    end else begin
      phase_q    <= phase_d;
      position_q <= position_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
`ifdef QUAD_GEN_INDEX_EN
      index_q    <= index_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign quadA    = phase_q[1];
  assign quadB    = phase_q[0];
  assign position = position_q;
  assign busy     = busy_s;
`ifdef QUAD_GEN_INDEX_EN
  assign index    = index_q;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// -----------------------------------------------------------------------------
// tb_quad_gen -- self-checking bench for quad_gen (W=8, DIV=4)
//
// A reference model advances an integer position towards the target once
// every DIV cycles and pushes each expected output change (position plus
// {quadA, quadB}) into a queue. A separate monitor pops that queue whenever
// the DUT outputs change and compares. A behavioural loopback decoder with a
// 3-stage synchroniser must track the model position with 3 cycles latency.
// Honours QUAD_GEN_INDEX_EN for the index output.
// -----------------------------------------------------------------------------
module tb_quad_gen;

  localparam int W    = 8;
  localparam int DIV  = 4;
  localparam int MOD  = 1 << W;
  localparam int HALF = MOD / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] target;
  logic         quadA;
  logic         quadB;
  logic [W-1:0] position;
  logic         busy;
`ifdef QUAD_GEN_INDEX_EN
  logic         index;
`endif

  quad_gen #(.W(W), .DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .target   (target),
    .load     (load),
    .quadA    (quadA),
    .quadB    (quadB),
    .position (position),
    .busy     (busy)
`ifdef QUAD_GEN_INDEX_EN
    ,
    .index    (index)
`endif
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int info);
    vectors++;
    miscompares++;
    $display("FAIL %s: value %0d", name, info);
  endtask

  // {quadA,quadB} for a position, from the phase sequence starting at 00.
  function automatic int gray(input int p);
    case (p % 4)
      0:       return 0;  // 00
      1:       return 2;  // 10
      2:       return 3;  // 11
      default: return 1;  // 01
    endcase
  endfunction

  // Inverse: which quarter of the cycle an {A,B} pair represents.
  function automatic int gidx(input int ab);
    case (ab)
      0:       return 0;
      2:       return 1;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  typedef struct {
    int val;   // {position, quadA, quadB}
    bit rst;   // change caused by reset
  } ev_t;

  ev_t q[$];

  // Reference model state
  bit started = 1'b0;
  int cyc      = 0;
  int last_rst = 0;
  int m_pos    = 0;
  int m_tgt    = 0;
  int m_next   = -1;  // cycle of the next step, -1 while idle
  int hist[8]  = '{default: 0};

  // Reference model: one step every DIV cycles along the shorter path.
  initial begin
    int  old_v;
    int  d;
    bit  was_busy;
    bit  step;
    wait (started);
    forever begin
      @(posedge clk);
      cyc++;
      old_v = m_pos * 4 + gray(m_pos);
      if (reset) begin
        m_pos    = 0;
        m_tgt    = 0;
        m_next   = -1;
        last_rst = cyc;
        if (old_v != 0) q.push_back('{0, 1'b1});
      end else begin
        was_busy = (m_pos != m_tgt);
        step     = was_busy && (cyc == m_next);
        if (step) begin
          d     = (m_tgt - m_pos + MOD) % MOD;
          m_pos = (d <= HALF) ? (m_pos + 1) % MOD : (m_pos + MOD - 1) % MOD;
        end
        if (load) m_tgt = int'(target);
        if (m_pos != m_tgt) begin
          if (step || !was_busy) m_next = cyc + DIV;
        end else begin
          m_next = -1;
        end
        if (step) q.push_back('{m_pos * 4 + gray(m_pos), 1'b0});
      end
      hist[cyc % 8] = m_pos;
    end
  end

  // Loopback decoder: 3-stage synchroniser, counts on the last two stages.
  int dec_cnt = 0;
  initial begin
    int s1, s2, s3, dd;
    s1 = 0; s2 = 0; s3 = 0;
    wait (started);
    forever begin
      @(posedge clk);
      if (reset) begin
        s1 = 0; s2 = 0; s3 = 0;
        dec_cnt = 0;
      end else begin
        dd = (gidx(s2) - gidx(s3) + 4) % 4;
        if (dd == 1)      dec_cnt = (dec_cnt + 1) % MOD;
        else if (dd == 3) dec_cnt = (dec_cnt + MOD - 1) % MOD;
        s3 = s2;
        s2 = s1;
        s1 = int'({quadA, quadB});
      end
    end
  end

  // Monitor: compares every output change against the scoreboard queue.
  initial begin
    int  prev, cur, last_edge;
    ev_t e;
    wait (started);
    prev      = int'({position, quadA, quadB});
    last_edge = -1000;
    forever begin
      @(posedge clk);
      #1;
      cur = int'({position, quadA, quadB});
      chk("busy", int'(busy), int'(m_pos != m_tgt));
`ifdef QUAD_GEN_INDEX_EN
      chk("index", int'(index), int'(m_pos == 0));
`endif
      if (cur != prev) begin
        if (q.size() == 0) begin
          chk("unexpected_edge", cur, prev);
        end else begin
          e = q.pop_front();
          chk("edge", cur, e.val);
          if (!e.rst) begin
            vectors++;
            if (cyc - last_edge < DIV) begin
              miscompares++;
              $display("FAIL edge_spacing: got %0d clocks, need at least %0d", cyc - last_edge, DIV);
            end
            last_edge = cyc;
          end
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        chk("missing_edge", cur, e.val);
      end
      if (cyc - last_rst >= 3) chk("decoder", dec_cnt, hist[(cyc - 3) % 8]);
      prev = cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_load(input int t);
    target = W'(t);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_pos != m_tgt || q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("idle_timeout", n);
  endtask

  task automatic wait_pos(input int p, input int budget);
    int n = 0;
    while (m_pos != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("pos_timeout", p);
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    target = '0;
    repeat (2) @(negedge clk);
    chk("reset_quadA", int'(quadA), 0);
    chk("reset_quadB", int'(quadB), 0);
    chk("reset_position", int'(position), 0);
    chk("reset_busy", int'(busy), 0);
`ifdef QUAD_GEN_INDEX_EN
    chk("reset_index", int'(index), 1);
`endif
    started = 1'b1;
    reset   = 1'b0;
    @(negedge clk);

    // Up move 0 -> 3
    do_load(3);
    wait_idle(100);
    chk("up_position", int'(position), 3);
    chk("up_ab", int'({quadA, quadB}), 1);

    // Loading the current position produces nothing
    do_load(3);
    repeat (2 * DIV) @(negedge clk);
    chk("same_target_busy", int'(busy), 0);
    chk("same_target_position", int'(position), 3);

    // Down wrap 0 -> FE
    do_reset();
    do_load(8'hFE);
    wait_idle(100);
    chk("wrap_position", int'(position), 8'hFE);
    chk("wrap_ab", int'({quadA, quadB}), 3);

    // Tie: 0 -> 0x80 goes up
    do_reset();
    do_load(8'h80);
    wait_pos(1, 20);
    chk("tie_direction", int'(position), 1);
    wait_idle(700);
    chk("tie_position", int'(position), 8'h80);

    // Retarget mid-move
    do_reset();
    do_load(10);
    wait_pos(4, 100);
    do_load(2);
    wait_idle(100);
    chk("retarget_position", int'(position), 2);
    chk("retarget_ab", int'({quadA, quadB}), 3);

    // Reset mid-move, with a load in the same cycle
    do_reset();
    do_load(10);
    wait_pos(5, 100);
    reset  = 1'b1;
    load   = 1'b1;
    target = 8'h33;
    @(negedge clk);
    reset  = 1'b0;
    load   = 1'b0;
    chk("midreset_ab", int'({quadA, quadB}), 0);
    chk("midreset_position", int'(position), 0);
    chk("midreset_busy", int'(busy), 0);
    repeat (3 * DIV) @(negedge clk);
    chk("midreset_load_ignored", int'(position), 0);

    // Random loads, rare resets
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      load  = ($urandom_range(0, 29) == 0);
      if (load) begin
        if ($urandom_range(0, 3) == 0) target = W'(m_pos);
        else                           target = W'($urandom_range(0, MOD - 1));
      end
      @(negedge clk);
    end
    reset = 1'b0;
    load  = 1'b0;
    wait_idle(1000);
    chk("final_queue_empty", q.size(), 0);
    chk("final_position", int'(position), m_tgt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
